time_set_ctrl: RTL

- User-facing controller that drives the `set`/`new_val` load port of the four time-digit registers (hour tens, hour units, minute tens, minute units); it is the initiator side of that load interface.
- Takes debounced mode/up/cancel buttons and walks the user through the digits one at a time.
- Edits a shadow copy with legal-range wrap per digit, then commits all four digits in one cycle.
- Also freezes the timebase while editing and produces a blink signal for the digit under edit.

---
 rtl/time_set_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks the user through the four time digits using debounced
// buttons, edits a shadow copy with per-digit wrap, and commits all digits in one cycle.
module time_set_ctrl #(
  parameter int unsigned BLINK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_cancel,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_u,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       set_hr_t,
  output logic       set_hr_u,
  output logic       set_min_t,
  output logic       set_min_u,
  output logic [3:0] new_hr_t,
  output logic [3:0] new_hr_u,
  output logic [3:0] new_min_t,
  output logic [3:0] new_min_u,
  output logic       time_hold,
  output logic [1:0] edit_sel,
  output logic       blink
);

  localparam int unsigned CntW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StEHrt,
    StEHru,
    StEMint,
    StEMinu,
    StCommit
  } state_e;

  state_e state_q, state_d;

  logic [3:0] hr_t_q, hr_t_d, hr_u_q, hr_u_d, min_t_q, min_t_d, min_u_q, min_u_d;
  logic       mode_prev_q, up_prev_q, cancel_prev_q;
  logic       armed_q;
  logic       mode_edge, up_edge, cancel_edge;
  logic       set_q;
  logic       time_hold_q;
  logic [1:0] edit_sel_q, edit_sel_d;
  logic       blink_q;
  logic [CntW-1:0] cnt_q;
  logic       cnt_clear;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? 4'd0 : v + 4'd1;
  endfunction

  // Edges are suppressed on the first clock after reset so a button held through
  // reset release never acts.
  assign mode_edge   = armed_q & btn_mode & ~mode_prev_q;
  assign up_edge     = armed_q & btn_up & ~up_prev_q;
  assign cancel_edge = armed_q & btn_cancel & ~cancel_prev_q;

  always_comb begin
    state_d = state_q;
    hr_t_d  = hr_t_q;
    hr_u_d  = hr_u_q;
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    unique case (state_q)
      StIdle: begin
        if (mode_edge) begin
          state_d = StEHrt;
          hr_t_d  = cur_hr_t;
          hr_u_d  = cur_hr_u;
          min_t_d = cur_min_t;
          min_u_d = cur_min_u;
        end
      end
      StEHrt: begin
        if (cancel_edge) begin
          state_d = StIdle;
        end else if (mode_edge) begin
          state_d = StEHru;
        end else if (up_edge) begin
          hr_t_d = wrap_inc(hr_t_q, 4'd2);
          // Stepping into the 20s must not leave an illegal hour like 24..29.
          if (hr_t_q == 4'd1 && hr_u_q > 4'd3) hr_u_d = 4'd0;
        end
      end
      StEHru: begin
        if (cancel_edge) begin
          state_d = StIdle;
        end else if (mode_edge) begin
          state_d = StEMint;
        end else if (up_edge) begin
          hr_u_d = wrap_inc(hr_u_q, (hr_t_q == 4'd2) ? 4'd3 : 4'd9);
        end
      end
      StEMint: begin
        if (cancel_edge) begin
          state_d = StIdle;
        end else if (mode_edge) begin
          state_d = StEMinu;
        end else if (up_edge) begin
          min_t_d = wrap_inc(min_t_q, 4'd5);
        end
      end
      StEMinu: begin
        if (cancel_edge) begin
          state_d = StIdle;
        end else if (mode_edge) begin
          state_d = StCommit;
        end else if (up_edge) begin
          min_u_d = wrap_inc(min_u_q, 4'd9);
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    edit_sel_d = edit_sel_q;
    unique case (state_d)
      StEHrt:  edit_sel_d = 2'd0;
      StEHru:  edit_sel_d = 2'd1;
      StEMint: edit_sel_d = 2'd2;
      StEMinu: edit_sel_d = 2'd3;
      default: edit_sel_d = edit_sel_q;
    endcase
  end

  // Blink phase restarts whenever the edited digit changes or editing stops.
  assign cnt_clear = (state_d != state_q) ||
                     !(state_q inside {StEHrt, StEHru, StEMint, StEMinu});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      hr_t_q        <= '0;
      hr_u_q        <= '0;
      min_t_q       <= '0;
      min_u_q       <= '0;
      mode_prev_q   <= 1'b0;
      up_prev_q     <= 1'b0;
      cancel_prev_q <= 1'b0;
      armed_q       <= 1'b0;
      set_q         <= 1'b0;
      time_hold_q   <= 1'b0;
      edit_sel_q    <= 2'd0;
      blink_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hr_t_q        <= hr_t_d;
      hr_u_q        <= hr_u_d;
      min_t_q       <= min_t_d;
      min_u_q       <= min_u_d;
      mode_prev_q   <= btn_mode;
      up_prev_q     <= btn_up;
      cancel_prev_q <= btn_cancel;
      armed_q       <= 1'b1;
      set_q         <= (state_d == StCommit);
      time_hold_q   <= (state_d != StIdle);
      edit_sel_q    <= edit_sel_d;
      if (cnt_clear) begin
        cnt_q   <= '0;
        blink_q <= 1'b0;
      end else if (cnt_q == CntW'(BLINK_CYCLES - 1)) begin
        cnt_q   <= '0;
        blink_q <= ~blink_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign set_hr_t  = set_q;
  assign set_hr_u  = set_q;
  assign set_min_t = set_q;
  assign set_min_u = set_q;
  assign new_hr_t  = hr_t_q;
  assign new_hr_u  = hr_u_q;
  assign new_min_t = min_t_q;
  assign new_min_u = min_u_q;
  assign time_hold = time_hold_q;
  assign edit_sel  = edit_sel_q;
  assign blink     = blink_q;

endmodule
